// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the binary-convolution run sequencer
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_CAP,
    H_ROWS,
    H_COLS,
    ROWS,
    DRAIN
  } state_t;

  localparam logic [15:0] END_WORD    = 16'h00FF;
  localparam int          WEIGHT_ADDR = 1;
  localparam int          KERNEL_DIM  = 3;
  localparam int          MIN_DIM     = 3;
  localparam int          MAX_COLS    = 16;
  localparam int          HDR_WORDS   = 2;

endpackage

// File: rtl/conv_write_tracker.sv
// rtl/conv_write_tracker.sv - outstanding-result counter and output SRAM write port
module conv_write_tracker #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              clear,
  input  logic              inc,
  input  logic              dp_out_valid,
  input  logic [DATA_W-1:0] dp_out_data,
  output logic [PEND_W-1:0] pending,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              write_enable
);

  logic [ADDR_W-1:0] waddr;
  logic              accept;

  // A result is only taken when a counted row is outstanding; anything else is dropped.
  assign accept = dp_out_valid && (pending != '0);

  // Register the write strobe/data one cycle after the result and track outstanding rows.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      pending       <= '0;
      waddr         <= '0;
      write_address <= '0;
      write_data    <= '0;
      write_enable  <= 1'b0;
    end else begin
      write_enable <= accept;
      if (accept) begin
        write_address <= waddr;
        write_data    <= dp_out_data;
      end
      if (clear) begin
        waddr   <= '0;
        pending <= '0;
      end else begin
        if (accept) begin
          waddr <= waddr + ADDR_W'(1);
        end
        if (inc && !accept && !(&pending)) begin
          pending <= pending + PEND_W'(1);
        end else if (accept && !inc) begin
          pending <= pending - PEND_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv_run_sequencer.sv
// rtl/conv_run_sequencer.sv - run/busy FSM, weight and image-list walker (optional CONV_SEQ_PERF_EN perf counters)
module conv_run_sequencer #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] END_WORD = conv_pkg::END_WORD,
  parameter int                PEND_W   = 4
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable,
  output logic              load_weights,
  output logic [8:0]        weights_data,
  output logic              image_start,
  output logic [4:0]        ncols,
  output logic              row_push,
  output logic [DATA_W-1:0] row_data,
  input  logic              dp_out_valid,
  input  logic [DATA_W-1:0] dp_out_data
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_cycles,
  output logic [7:0]        perf_images
`endif
);

  import conv_pkg::*;

  state_t            state, state_n;
  logic              busy_q, busy_n;
  logic [ADDR_W-1:0] wmem_addr_q, wmem_addr_n;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [DATA_W-1:0] nrows_q, nrows_n;
  logic [DATA_W-1:0] rowcnt_q, rowcnt_n;
  logic [8:0]        weights_q, weights_n;
  logic              load_w_q, load_w_n;
  logic              img_start_q, img_start_n;
  logic [4:0]        ncols_q, ncols_n;
  logic              push_q, push_n;
  logic [DATA_W-1:0] row_data_q, row_data_n;
  logic              run_accept;
  logic              push_count;
  logic [PEND_W-1:0] pending;
  logic [4:0]        cols_clamped;
  logic [ADDR_W-1:0] next_base;
  logic              unused_wmem_bits;

  // Only the 3x3 kernel bits of the weight word are meaningful.
  assign unused_wmem_bits = &{1'b0, wmem_dut_read_data[DATA_W-1:9]};

  // Any ncols word above the physical row width collapses to the maximum.
  assign cols_clamped = (sram_dut_read_data > DATA_W'(MAX_COLS)) ? 5'(MAX_COLS)
                                                                  : sram_dut_read_data[4:0];
  // The next header sits right after this image's rows.
  assign next_base = base_q + ADDR_W'(HDR_WORDS) + nrows_q[ADDR_W-1:0];

  // Next-state and next-output decode; every register holds unless a state says otherwise.
  always_comb begin
    state_n     = state;
    busy_n      = busy_q;
    wmem_addr_n = wmem_addr_q;
    sram_addr_n = sram_addr_q;
    base_n      = base_q;
    nrows_n     = nrows_q;
    rowcnt_n    = rowcnt_q;
    weights_n   = weights_q;
    ncols_n     = ncols_q;
    row_data_n  = row_data_q;
    load_w_n    = 1'b0;
    img_start_n = 1'b0;
    push_n      = 1'b0;
    run_accept  = 1'b0;
    push_count  = 1'b0;
    case (state)
      IDLE: begin
        if (dut_run) begin
          run_accept  = 1'b1;
          busy_n      = 1'b1;
          wmem_addr_n = ADDR_W'(WEIGHT_ADDR);
          base_n      = '0;
          state_n     = W_CAP;
        end
      end
      W_CAP: begin
        weights_n   = wmem_dut_read_data[8:0];
        load_w_n    = 1'b1;
        sram_addr_n = base_q;
        state_n     = H_ROWS;
      end
      H_ROWS: begin
        if (sram_dut_read_data == END_WORD) begin
          state_n = DRAIN;
        end else begin
          nrows_n     = sram_dut_read_data;
          sram_addr_n = base_q + ADDR_W'(1);
          state_n     = H_COLS;
        end
      end
      H_COLS: begin
        ncols_n = cols_clamped;
        if ((nrows_q < DATA_W'(MIN_DIM)) || (cols_clamped < 5'(MIN_DIM))) begin
          base_n      = next_base;
          sram_addr_n = next_base;
          state_n     = H_ROWS;
        end else begin
          img_start_n = 1'b1;
          sram_addr_n = base_q + ADDR_W'(HDR_WORDS);
          rowcnt_n    = '0;
          state_n     = ROWS;
        end
      end
      ROWS: begin
        push_n      = 1'b1;
        row_data_n  = sram_dut_read_data;
        sram_addr_n = sram_addr_q + ADDR_W'(1);
        rowcnt_n    = rowcnt_q + DATA_W'(1);
        // The first KERNEL_DIM-1 rows of an image only fill the window.
        push_count  = (rowcnt_q >= DATA_W'(KERNEL_DIM - 1));
        if (rowcnt_q == nrows_q - DATA_W'(1)) begin
          base_n      = next_base;
          sram_addr_n = next_base;
          state_n     = H_ROWS;
        end
      end
      DRAIN: begin
        if ((pending == '0) && !dut_sram_write_enable) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Registered addresses, header fields and datapath strobes.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      busy_q      <= 1'b0;
      wmem_addr_q <= '0;
      sram_addr_q <= '0;
      base_q      <= '0;
      nrows_q     <= '0;
      rowcnt_q    <= '0;
      weights_q   <= '0;
      load_w_q    <= 1'b0;
      img_start_q <= 1'b0;
      ncols_q     <= '0;
      push_q      <= 1'b0;
      row_data_q  <= '0;
    end else begin
      busy_q      <= busy_n;
      wmem_addr_q <= wmem_addr_n;
      sram_addr_q <= sram_addr_n;
      base_q      <= base_n;
      nrows_q     <= nrows_n;
      rowcnt_q    <= rowcnt_n;
      weights_q   <= weights_n;
      load_w_q    <= load_w_n;
      img_start_q <= img_start_n;
      ncols_q     <= ncols_n;
      push_q      <= push_n;
      row_data_q  <= row_data_n;
    end
  end

  conv_write_tracker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .PEND_W(PEND_W)
  ) u_write_tracker (
    .clk          (clk),
    .reset_b      (reset_b),
    .clear        (run_accept),
    .inc          (push_count),
    .dp_out_valid (dp_out_valid),
    .dp_out_data  (dp_out_data),
    .pending      (pending),
    .write_address(dut_sram_write_address),
    .write_data   (dut_sram_write_data),
    .write_enable (dut_sram_write_enable)
  );

  assign dut_busy              = busy_q;
  assign dut_wmem_read_address = wmem_addr_q;
  assign dut_sram_read_address = sram_addr_q;
  assign load_weights          = load_w_q;
  assign weights_data          = weights_q;
  assign image_start           = img_start_q;
  assign ncols                 = ncols_q;
  assign row_push              = push_q;
  assign row_data              = row_data_q;

`ifdef CONV_SEQ_PERF_EN
  // Busy-cycle and processed-image counters; cleared on a new run, frozen once idle.
  always_ff @(posedge clk) begin
    if (reset_b || run_accept) begin
      perf_cycles <= '0;
      perf_images <= '0;
    end else begin
      if (busy_q && !(&perf_cycles)) begin
        perf_cycles <= perf_cycles + 16'd1;
      end
      if (img_start_q && !(&perf_images)) begin
        perf_images <= perf_images + 8'd1;
      end
    end
  end
`endif

endmodule

// File: doc/conv_run_sequencer.md
Name: conv_run_sequencer

Overview:
- Top-level sequencer for the 3x3 binary-convolution datapath.
- Owns the dut_run/dut_busy handshake and the weight-memory and input-SRAM read addressing.
- Walks the packed image list until the end word is read, then streams datapath results to the output SRAM and drops busy once all results are written.
- Sits between the SRAM ports and the conv-module array / full-adder tree, replacing ad-hoc strobe generation with one FSM.

Parameters:
- ADDR_W, 12, SRAM/WMEM address width
- DATA_W, 16, SRAM word width; max row width in columns
- END_WORD, 16'h00FF, nrows value that terminates the image list
- PEND_W, 4, width of the outstanding-result counter

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_b  in  1  synchronous reset, active-high (1 = reset)
- dut_run  in  1  start request, sampled in IDLE only
- dut_busy  out  1  high from cycle after accepted run until last write done
- dut_wmem_read_address  out  ADDR_W  weight memory read address
- wmem_dut_read_data  in  DATA_W  weight word, valid 1 cycle after address
- dut_sram_read_address  out  ADDR_W  input SRAM read address
- sram_dut_read_data  in  DATA_W  input word, valid 1 cycle after address
- dut_sram_write_address  out  ADDR_W  output SRAM write address
- dut_sram_write_data  out  DATA_W  output row word
- dut_sram_write_enable  out  1  write strobe
- load_weights  out  1  1-cycle pulse; weights valid on weights_data
- weights_data  out  9  kernel bits, [2:0] row0, [5:3] row1, [8:6] row2
- image_start  out  1  1-cycle pulse before first row of an image; datapath flushes its row window
- ncols  out  5  column count of current image, clamped to 16
- row_push  out  1  row_data valid; datapath shifts one row in
- row_data  out  DATA_W  input row, bit c = column c
- dp_out_valid  in  1  datapath result row valid
- dp_out_data  in  DATA_W  result row, bits [ncols-3:0] significant

Behaviour:
- Reset values: dut_busy=0, all addresses=0, write_enable=0, write_data=0, all pulses=0, weights_data=0, ncols=0, pending=0, FSM=IDLE.
- Reset mid-run aborts at the next edge; no partial write completes after the reset edge.
- Memory layout:
  - wmem[1][8:0] holds the weights; wmem[0] (dims) is not read, the kernel is fixed 3x3.
  - Per image: nrows, ncols, then nrows row words.
  - The next image header follows immediately after the last row.
  - Outputs are written to consecutive addresses from 0.
- IDLE: dut_run=1 -> busy=1, wmem addr=1, base=0 -> W_CAP. dut_run while busy is ignored.
- W_CAP: latch wmem_dut_read_data[8:0] into weights_data, pulse load_weights, sram addr=base -> H_ROWS.
- H_ROWS (nrows data arrives):
  - If data == END_WORD -> DRAIN.
  - Else latch nrows, addr=base+1 -> H_COLS.
- H_COLS:
  - Latch ncols = min(data[4:0],16); data[15:5] nonzero also clamps to 16.
  - If nrows<3 or ncols<3: skip the image; base += 2+nrows, addr=base -> H_ROWS. No pushes, no outputs.
  - Else pulse image_start, addr=base+2, rowcnt=0 -> ROWS.
- ROWS:
  - Each cycle: row_push=1 and row_data=read data for the previous address; address increments.
  - rowcnt++; rows with rowcnt>=2 increment pending.
  - After the push with rowcnt==nrows-1: base += 2+nrows, addr=base -> H_ROWS.
  - Throughput is 1 row/cycle.
- Write path (any state):
  - dp_out_valid=1 -> next cycle write_enable=1, data=dp_out_data, address=waddr; waddr++ (mod 2^ADDR_W); pending--.
  - A simultaneous push-increment and write-decrement leaves pending unchanged.
  - dp_out_valid while pending==0 is dropped.
- DRAIN: wait pending==0 and no write in flight -> busy=0 -> IDLE.
- Address arithmetic wraps modulo 2^ADDR_W. Pending saturates at all-ones; the datapath latency must stay below 2^PEND_W rows.
- A new run restarts waddr at 0.

Optional Feature:
- CONV_SEQ_PERF_EN defined:
  - Adds outputs perf_cycles (16b, busy cycles, saturating) and perf_images (8b, processed images excluding skipped, saturating).
  - Both clear on run acceptance and hold after busy falls.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package conv_pkg: FSM state enum (IDLE, W_CAP, H_ROWS, H_COLS, ROWS, DRAIN), END_WORD, WEIGHT_ADDR=1, KERNEL_DIM=3, MIN_DIM=3.
- One natural sub-module: conv_write_tracker, which holds the pending counter, the write-address register and the write-strobe register.

Test Plan:
- Single 4x4 image, all-ones weights, rows 16'h000F, END after it -> load_weights once; 4 pushes; 2 writes at addresses 0,1; busy falls after the second write.
- Image list 5x8 then 3x3 then END -> pushes 5 then 3, image_start twice, header reads at 0,1,7,8, END read at address 12; 4 writes at addresses 0..3.
- nrows=2 image followed by a 3x3 image -> no pushes for the first image; the second header is read at address 4; 1 write.
- ncols word 16'h0020 -> ncols output = 16.
- dut_run pulsed mid-run, then reset_b asserted during ROWS -> the mid-run run is ignored; the next cycle after reset shows all outputs at reset values and pending=0. A subsequent run starts writing at address 0.
- dp_out_valid asserted on the same cycle as a counted push, with pending=1 -> pending stays 1; a spurious dp_out_valid with pending=0 -> no write.
